// File: rtl/tune_ctrl.sv
// Command-driven LO tuning controller: parses UART bytes, owns the NCO increment.
// Optional TUNE_READBACK_EN adds the 'Q' readback opcode.
module tune_ctrl #(
  parameter logic [63:0] DEFAULT_INC = 64'h01B1B1B1B1B1B1B1,
  parameter logic [63:0] STEP_INC    = 64'h00045641C6E59DF0,
  parameter logic [63:0] MIN_INC     = 64'h0000F0F0F0F0F0F0,
  parameter logic [63:0] MAX_INC     = 64'h0333333333333333,
  parameter int unsigned TIMEOUT_CYC = 1360000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        tx_busy,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  output logic [63:0] phase_inc,
  output logic        inc_upd,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, APPLY, ACK_WAIT, ACK
  } state_t;

  typedef enum logic [1:0] {
    OP_F, OP_P, OP_M, OP_D
  } op_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [63:0] MIN_DEC = MIN_INC + STEP_INC;
  localparam logic [7:0] CH_OK = 8'h4B;
  localparam logic [7:0] CH_ER = 8'h45;

  state_t state, state_n;
  op_t op, op_n;
  logic [63:0] shadow, shadow_n;
  logic [2:0]  byte_cnt, byte_cnt_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic        res_ok, res_ok_n;
  logic [63:0] inc_n;
  logic        upd_n, err_n, txdv_n;
  logic [7:0]  txb_n;
  logic [64:0] sum;
  logic        ok;
  logic [63:0] cand;
`ifdef TUNE_READBACK_EN
  logic [63:0] snap, snap_n;
  logic [3:0]  rd_cnt, rd_cnt_n;
  logic        rd_mode, rd_mode_n;
`endif

  always_comb begin
    sum  = {1'b0, phase_inc} + {1'b0, STEP_INC};
    ok   = 1'b0;
    cand = phase_inc;
    unique case (op)
      OP_F: begin
        ok   = (shadow >= MIN_INC) && (shadow <= MAX_INC);
        cand = shadow;
      end
      OP_P: begin
        ok   = !sum[64] && (sum[63:0] <= MAX_INC);
        cand = sum[63:0];
      end
      OP_M: begin
        ok   = phase_inc >= MIN_DEC;
        cand = phase_inc - STEP_INC;
      end
      OP_D: begin
        ok   = 1'b1;
        cand = DEFAULT_INC;
      end
    endcase
  end

  always_comb begin
    state_n    = state;
    op_n       = op;
    shadow_n   = shadow;
    byte_cnt_n = byte_cnt;
    tmo_n      = tmo_cnt;
    res_ok_n   = res_ok;
    inc_n      = phase_inc;
    upd_n      = 1'b0;
    err_n      = 1'b0;
    txdv_n     = 1'b0;
    txb_n      = tx_byte;
`ifdef TUNE_READBACK_EN
    snap_n     = snap;
    rd_cnt_n   = rd_cnt;
    rd_mode_n  = rd_mode;
`endif
    unique case (state)
      IDLE: begin
        if (rx_dv) begin
          unique case (1'b1)
            (rx_byte == 8'h46): begin
              state_n    = LOAD;
              op_n       = OP_F;
              byte_cnt_n = '0;
              tmo_n      = '0;
            end
            (rx_byte == 8'h2B): begin
              state_n = APPLY;
              op_n    = OP_P;
            end
            (rx_byte == 8'h2D): begin
              state_n = APPLY;
              op_n    = OP_M;
            end
            (rx_byte == 8'h44): begin
              state_n = APPLY;
              op_n    = OP_D;
            end
`ifdef TUNE_READBACK_EN
            (rx_byte == 8'h51): begin
              state_n   = ACK_WAIT;
              snap_n    = phase_inc;
              rd_cnt_n  = '0;
              rd_mode_n = 1'b1;
              res_ok_n  = 1'b1;
            end
`endif
            default: begin
              state_n  = ACK_WAIT;
              res_ok_n = 1'b0;
              err_n    = 1'b1;
            end
          endcase
        end
      end
      LOAD: begin
        if (rx_dv) begin
          shadow_n   = {shadow[55:0], rx_byte};
          tmo_n      = '0;
          byte_cnt_n = byte_cnt + 3'd1;
          if (byte_cnt == 3'd7)
            state_n = APPLY;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n  = ACK_WAIT;
          shadow_n = '0;
          res_ok_n = 1'b0;
          err_n    = 1'b1;
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      APPLY: begin
        state_n = ACK_WAIT;
        err_n   = rx_dv;
        if (ok) begin
          inc_n    = cand;
          upd_n    = 1'b1;
          res_ok_n = 1'b1;
        end else begin
          err_n    = 1'b1;
          res_ok_n = 1'b0;
        end
      end
      ACK_WAIT: begin
        err_n = rx_dv;
        if (!tx_busy) begin
          state_n = ACK;
          txdv_n  = 1'b1;
          txb_n   = res_ok ? CH_OK : CH_ER;
`ifdef TUNE_READBACK_EN
          if (rd_mode && (rd_cnt < 4'd8))
            txb_n = snap[63:56];
`endif
        end
      end
      ACK: begin
        err_n   = rx_dv;
        state_n = IDLE;
`ifdef TUNE_READBACK_EN
        // readback streams snapshot bytes, then a final 'K'
        if (rd_mode && (rd_cnt < 4'd8)) begin
          state_n  = ACK_WAIT;
          rd_cnt_n = rd_cnt + 4'd1;
          snap_n   = {snap[55:0], 8'h00};
        end else begin
          rd_mode_n = 1'b0;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= OP_D;
      shadow    <= '0;
      byte_cnt  <= '0;
      tmo_cnt   <= '0;
      res_ok    <= 1'b0;
      phase_inc <= DEFAULT_INC;
      inc_upd   <= 1'b0;
      frame_err <= 1'b0;
      tx_dv     <= 1'b0;
      tx_byte   <= '0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      shadow    <= shadow_n;
      byte_cnt  <= byte_cnt_n;
      tmo_cnt   <= tmo_n;
      res_ok    <= res_ok_n;
      phase_inc <= inc_n;
      inc_upd   <= upd_n;
      frame_err <= err_n;
      tx_dv     <= txdv_n;
      tx_byte   <= txb_n;
    end
  end

`ifdef TUNE_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap    <= '0;
      rd_cnt  <= '0;
      rd_mode <= 1'b0;
    end else begin
      snap    <= snap_n;
      rd_cnt  <= rd_cnt_n;
      rd_mode <= rd_mode_n;
    end
  end
`endif

endmodule

// File: tb/tb_tune_ctrl.sv
// Directed bench for tune_ctrl: tuning ops, range limits, timeout,
// tx back-pressure, reset mid-frame and the optional readback.
module tb_tune_ctrl;

  localparam logic [63:0] DEF = 64'h01B1B1B1B1B1B1B1;
  localparam logic [63:0] P1  = 64'h01B607F378974FA1;
  localparam logic [63:0] F1  = 64'h0104376A9DD10437;
  localparam logic [63:0] M1  = 64'h00FFE128D6EB6647;
  localparam logic [63:0] MIN = 64'h0000F0F0F0F0F0F0;
  localparam logic [63:0] MAX = 64'h0333333333333333;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_busy = 1'b0;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [63:0] phase_inc;
  logic        inc_upd;
  logic        frame_err;

  int total = 0;
  int bad = 0;
  int upd_cnt = 0;
  int err_cnt = 0;
  logic [7:0] txq[$];

  tune_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_dv(rx_dv), .rx_byte(rx_byte),
    .tx_busy(tx_busy), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .phase_inc(phase_inc), .inc_upd(inc_upd),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (inc_upd) upd_cnt++;
      if (frame_err) err_cnt++;
      if (tx_dv) txq.push_back(tx_byte);
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    upd_cnt = 0;
    err_cnt = 0;
    txq.delete();
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_dv = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int i = 0;
    while (txq.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (txq.size() < n)
      chk("tx_timeout", 64'(txq.size()), 64'(n));
    repeat (3) @(negedge clk);
  endtask

  task automatic ack(input string tag, input logic [7:0] exp,
                     input int budget);
    logic [7:0] got;
    wait_tx(1, budget);
    got = (txq.size() > 0) ? txq[0] : 8'hxx;
    chk({tag, "_n"}, 64'(txq.size()), 64'd1);
    chk(tag, 64'(got), 64'(exp));
  endtask

  task automatic load_f(input logic [63:0] v);
    send(8'h46);
    for (int i = 0; i < 8; i++)
      send(v[63-8*i -: 8]);
  endtask

  initial begin
    logic [7:0] rb [9];
    rb[0] = 8'h01;
    for (int i = 1; i < 8; i++) rb[i] = 8'hB1;
    rb[8] = 8'h4B;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_inc", phase_inc, DEF);
    chk("rst_txdv", 64'(tx_dv), 64'd0);
    chk("rst_txb", 64'(tx_byte), 64'd0);
    chk("rst_upd", 64'(inc_upd), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);

    clr();
    send(8'h2B);
    chk("plus_lat", phase_inc, DEF);
    @(negedge clk);
    chk("plus_inc", phase_inc, P1);
    chk("plus_upd", 64'(inc_upd), 64'd1);
    ack("plus_ack", 8'h4B, 20);
    chk("plus_updn", 64'(upd_cnt), 64'd1);

    clr();
    load_f(F1);
    ack("f1_ack", 8'h4B, 20);
    chk("f1_inc", phase_inc, F1);
    chk("f1_updn", 64'(upd_cnt), 64'd1);

    clr();
    load_f(64'd0);
    ack("f0_ack", 8'h45, 20);
    chk("f0_inc", phase_inc, F1);
    chk("f0_err", 64'(err_cnt), 64'd1);
    chk("f0_upd", 64'(upd_cnt), 64'd0);

    clr();
    send(8'h2D);
    ack("minus_ack", 8'h4B, 20);
    chk("minus_inc", phase_inc, M1);

    clr();
    load_f(MIN);
    ack("fmin_ack", 8'h4B, 20);
    chk("fmin_inc", phase_inc, MIN);
    clr();
    send(8'h2D);
    ack("mmin_ack", 8'h45, 20);
    chk("mmin_inc", phase_inc, MIN);
    chk("mmin_err", 64'(err_cnt), 64'd1);

    clr();
    load_f(MAX);
    ack("fmax_ack", 8'h4B, 20);
    chk("fmax_inc", phase_inc, MAX);
    clr();
    send(8'h2B);
    ack("pmax_ack", 8'h45, 20);
    chk("pmax_inc", phase_inc, MAX);
    chk("pmax_upd", 64'(upd_cnt), 64'd0);

    clr();
    send(8'h46);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    ack("tmo_ack", 8'h45, TMO + 50);
    chk("tmo_inc", phase_inc, MAX);
    chk("tmo_err", 64'(err_cnt), 64'd1);

    clr();
    send(8'h44);
    ack("d_ack", 8'h4B, 20);
    chk("d_inc", phase_inc, DEF);
    chk("d_upd", 64'(upd_cnt), 64'd1);
    clr();
    send(8'h44);
    ack("dd_ack", 8'h4B, 20);
    chk("dd_upd", 64'(upd_cnt), 64'd1);

    clr();
    tx_busy = 1'b1;
    send(8'h2B);
    repeat (10) @(negedge clk);
    send(8'h41);
    repeat (490) @(negedge clk);
    chk("busy_txn", 64'(txq.size()), 64'd0);
    chk("busy_err", 64'(err_cnt), 64'd1);
    chk("busy_inc", phase_inc, P1);
    tx_busy = 1'b0;
    ack("busy_ack", 8'h4B, 20);
    repeat (20) @(negedge clk);
    chk("busy_once", 64'(txq.size()), 64'd1);
    chk("busy_upd", 64'(upd_cnt), 64'd1);

    clr();
    send(8'h46);
    for (int i = 0; i < 5; i++) send(8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_inc", phase_inc, DEF);
    chk("mid_rst_txdv", 64'(tx_dv), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    clr();
    send(8'h51);
`ifdef TUNE_READBACK_EN
    wait_tx(9, 100);
    chk("q_n", 64'(txq.size()), 64'd9);
    for (int i = 0; i < 9; i++)
      chk("q_byte", 64'((txq.size() > i) ? txq[i] : 8'hxx), 64'(rb[i]));
    chk("q_upd", 64'(upd_cnt), 64'd0);
    chk("q_err", 64'(err_cnt), 64'd0);
`else
    ack("q_ack", 8'h45, 20);
    chk("q_err", 64'(err_cnt), 64'd1);
`endif
    chk("q_inc", phase_inc, DEF);

    clr();
    send(8'h2B);
    ack("post_ack", 8'h4B, 20);
    chk("post_inc", phase_inc, P1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
